// File: rtl/systolic_operand_feeder_if.sv
// Load stream and array-drive signals of the systolic operand feeder.
interface systolic_operand_feeder_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            arr_clr;
  logic [N*DW-1:0] north_data;
  logic [N*DW-1:0] west_data;
  logic            busy;
  logic            tile_done;

  // Tile source / array observer side
  modport master (
    output in_valid, in_data,
    input  in_ready, arr_clr, north_data, west_data, busy, tile_done
  );

  // Feeder side
  modport slave (
    input  in_valid, in_data,
    output in_ready, arr_clr, north_data, west_data, busy, tile_done
  );
endinterface

// File: rtl/systolic_operand_feeder.sv
// Buffers one A tile and one B tile, then clears and feeds an N x N
// output-stationary MAC array: north columns unskewed, west rows skewed by row.
module systolic_operand_feeder #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  systolic_operand_feeder_if.slave bus
);
  localparam int unsigned NN        = N * N;
  localparam int unsigned AW        = $clog2(NN);
  localparam int unsigned CW        = $clog2(2 * NN);
  localparam int unsigned FW        = $clog2(2 * N);
  localparam int unsigned LAST_WORD = 2 * NN - 1;
  localparam int unsigned LAST_FEED = 2 * N - 2;

  typedef enum logic [1:0] {LOAD, CLEAR, FEED, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   load_cnt;
  logic [FW-1:0]   feed_cnt;
  logic [DW-1:0]   a_buf [NN];
  logic [DW-1:0]   b_buf [NN];
  logic [N*DW-1:0] north_nxt;
  logic [N*DW-1:0] west_nxt;
  int              feed_idx;
  logic            load_fire_c;

  assign load_fire_c = (state == LOAD) && bus.in_valid && bus.in_ready;

  // Tile buffers: first NN words are A row-major, next NN words are B row-major
  always_ff @(posedge clk) begin
    if (load_fire_c) begin
      if (load_cnt < CW'(NN))
        a_buf[AW'(load_cnt)] <= bus.in_data;
      else
        b_buf[AW'(load_cnt - CW'(NN))] <= bus.in_data;
    end
  end

  // Operands for the feed index that the next edge will present
  always_comb begin
    north_nxt = '0;
    west_nxt  = '0;
    feed_idx  = (state == FEED) ? int'(feed_cnt) + 1 : 0;
    for (int j = 0; j < int'(N); j++) begin
      if (feed_idx < int'(N))
        north_nxt[j*DW +: DW] = b_buf[AW'(feed_idx * int'(N) + j)];
    end
    // Row i pairs A[i][k] with B[k][j] once column data has rippled down i rows
    for (int i = 0; i < int'(N); i++) begin
      if (feed_idx >= i && feed_idx < i + int'(N))
        west_nxt[i*DW +: DW] = a_buf[AW'(i * int'(N) + feed_idx - i)];
    end
  end

  // Sequencer: LOAD -> CLEAR -> FEED (2N-1 cycles) -> DONE, all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= LOAD;
      load_cnt       <= '0;
      feed_cnt       <= '0;
      bus.in_ready   <= 1'b1;
      bus.arr_clr    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.tile_done  <= 1'b0;
      bus.north_data <= '0;
      bus.west_data  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (load_fire_c) begin
            if (load_cnt == CW'(LAST_WORD)) begin
              state        <= CLEAR;
              load_cnt     <= '0;
              bus.in_ready <= 1'b0;
              bus.arr_clr  <= 1'b1;
              bus.busy     <= 1'b1;
            end else begin
              load_cnt <= load_cnt + CW'(1);
            end
          end
        end
        CLEAR: begin
          state          <= FEED;
          feed_cnt       <= '0;
          bus.arr_clr    <= 1'b0;
          bus.north_data <= north_nxt;
          bus.west_data  <= west_nxt;
        end
        FEED: begin
          if (feed_cnt == FW'(LAST_FEED)) begin
            state          <= DONE;
            feed_cnt       <= '0;
            bus.tile_done  <= 1'b1;
            bus.north_data <= '0;
            bus.west_data  <= '0;
          end else begin
            feed_cnt       <= feed_cnt + FW'(1);
            bus.north_data <= north_nxt;
            bus.west_data  <= west_nxt;
          end
        end
        DONE: begin
          state         <= LOAD;
          bus.tile_done <= 1'b0;
          bus.busy      <= 1'b0;
          bus.in_ready  <= 1'b1;
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Bench for systolic_operand_feeder: tile timeline model, reference MAC array,
// and directed tiles with hand-computed results.
module tb_systolic_operand_feeder;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int NN = N * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_operand_feeder_if #(.N(N), .DW(DW)) bus ();
  systolic_operand_feeder #(.N(N), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic longint lane(input logic [N*DW-1:0] v, input int k);
    logic signed [DW-1:0] t;
    t = v[k*DW +: DW];
    return longint'(t);
  endfunction

  // Tile timeline model: phase 0 = loading, 1 = clear, 2..2N = feed f = phase-2, 2N+1 = done
  int     m_phase = 0;
  int     m_cnt   = 0;
  longint mA [NN];
  longint mB [NN];
  int     xfers   = 0;
  bit     started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      started = 1'b1;
      m_phase = 0;
      m_cnt   = 0;
      xfers   = 0;
    end else begin
      if (m_phase == 2 * N + 1) xfers = 0;
      else if (bus.in_valid && bus.in_ready) xfers++;
      if (m_phase == 0) begin
        if (bus.in_valid) begin
          logic signed [DW-1:0] w;
          w = bus.in_data;
          if (m_cnt < NN) mA[m_cnt] = longint'(w);
          else mB[m_cnt - NN] = longint'(w);
          m_cnt++;
          if (m_cnt == 2 * NN) begin
            m_phase = 1;
            m_cnt   = 0;
          end
        end
      end else if (m_phase == 2 * N + 1) begin
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
  end

  // Reference output-stationary array driven by the DUT's outputs
  longint acc  [N][N];
  longint nreg [N][N];
  longint nin  [N][N];

  always @(posedge clk) begin
    if (bus.arr_clr) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j]  = 0;
          nreg[i][j] = 0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          nin[i][j] = (i == 0) ? lane(bus.north_data, j) : nreg[i-1][j];
          acc[i][j] += lane(bus.west_data, i) * nin[i][j];
        end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) nreg[i][j] = nin[i][j];
    end
  end

  // Per-cycle comparison against the timeline model
  always @(negedge clk) begin
    if (started) begin
      int     p;
      int     f;
      longint en;
      longint ew;
      longint s;
      p = m_phase;
      f = p - 2;
      chk("in_ready", longint'(bus.in_ready), (p == 0) ? 1 : 0);
      chk("arr_clr", longint'(bus.arr_clr), (p == 1) ? 1 : 0);
      chk("busy", longint'(bus.busy), (p != 0) ? 1 : 0);
      chk("tile_done", longint'(bus.tile_done), (p == 2 * N + 1) ? 1 : 0);
      for (int k = 0; k < N; k++) begin
        en = 0;
        ew = 0;
        if (p >= 2 && p <= 2 * N) begin
          if (f < N) en = mB[f * N + k];
          if (f >= k && f < k + N) ew = mA[k * N + f - k];
        end
        chk($sformatf("north[%0d] p%0d", k, p), lane(bus.north_data, k), en);
        chk($sformatf("west[%0d] p%0d", k, p), lane(bus.west_data, k), ew);
      end
      if (p == 2 * N + 1) begin
        chk("tile_transfers", xfers, 2 * NN);
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < N; k++) s += mA[i * N + k] * mB[k * N + j];
            chk($sformatf("C[%0d][%0d]", i, j), acc[i][j], s);
          end
      end
    end
  end

  // Stimulus helpers
  int wbuf [2 * NN];
  bit first_after_done;

  task automatic load(input int nwords, input bit toggle, input bit hold);
    int idx   = 0;
    int guard = 0;
    bit v;
    bit prev_done = 1'b0;
    while (idx < nwords && guard < 2000) begin
      @(negedge clk);
      guard++;
      v = toggle ? bit'(guard % 2) : 1'b1;
      bus.in_valid = v;
      bus.in_data  = DW'(wbuf[idx]);
      if (v && bus.in_ready) begin
        if (idx == 0) first_after_done = prev_done;
        idx++;
      end
      prev_done = bus.tile_done;
    end
    if (idx < nwords) chk("load_timeout", idx, nwords);
    if (!hold) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!bus.tile_done && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    if (!bus.tile_done) chk("done_timeout", cycles, -1);
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        case (kind)
          1: begin wbuf[r*N+c] = (r == c) ? 1 : 0;      wbuf[NN+r*N+c] = r * 4 + c; end
          2: begin wbuf[r*N+c] = 10 * r + c;             wbuf[NN+r*N+c] = 1;         end
          3: begin wbuf[r*N+c] = -1;                     wbuf[NN+r*N+c] = 2;         end
          5: begin wbuf[r*N+c] = r + c;                  wbuf[NN+r*N+c] = (r == c) ? 1 : 0; end
          7: begin wbuf[r*N+c] = (r == c) ? 2 : 0;      wbuf[NN+r*N+c] = r - c;     end
          8: begin wbuf[r*N+c] = 1;                      wbuf[NN+r*N+c] = c;         end
          default: begin wbuf[r*N+c] = 99;               wbuf[NN+r*N+c] = 99;        end
        endcase
      end
  endtask

  initial begin
    int cyc;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst in_ready", longint'(bus.in_ready), 1);
    chk("rst busy", longint'(bus.busy), 0);
    chk("rst north", longint'(bus.north_data != '0), 0);
    rst = 1'b0;

    // Identity A, B[r][c] = 4r+c, continuous valid
    fill(1);
    load(2 * NN, 1'b0, 1'b0);
    chk("t1 clear", longint'(bus.arr_clr), 1);
    wait_done(cyc);
    chk("t1 clear_to_done", cyc, 2 * N);
    chk("t1 C[0][0]", acc[0][0], 0);
    chk("t1 C[2][3]", acc[2][3], 11);
    chk("t1 C[3][1]", acc[3][1], 13);

    // Skew: A[i][k] = 10i+k, B = 1
    fill(2);
    load(2 * NN, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("skew f3 w0", lane(bus.west_data, 0), 3);
    chk("skew f3 w1", lane(bus.west_data, 1), 12);
    chk("skew f3 w2", lane(bus.west_data, 2), 21);
    chk("skew f3 w3", lane(bus.west_data, 3), 30);
    repeat (2) @(negedge clk);
    chk("skew f5 w3", lane(bus.west_data, 3), 32);
    chk("skew f5 w0", lane(bus.west_data, 0), 0);
    chk("skew f5 w1", lane(bus.west_data, 1), 0);
    chk("skew f5 north", longint'(bus.north_data != '0), 0);
    wait_done(cyc);
    chk("skew C[3][0]", acc[3][0], 126);

    // Throttled load with negative operands
    fill(3);
    load(2 * NN, 1'b1, 1'b0);
    wait_done(cyc);
    chk("thr C[0][0]", acc[0][0], -8);
    chk("thr C[3][3]", acc[3][3], -8);

    // Reset at feed index 2
    fill(1);
    load(2 * NN, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstfeed in_ready", longint'(bus.in_ready), 1);
    chk("rstfeed busy", longint'(bus.busy), 0);
    chk("rstfeed done", longint'(bus.tile_done), 0);
    chk("rstfeed west", longint'(bus.west_data != '0), 0);
    rst = 1'b0;
    fill(5);
    load(2 * NN, 1'b0, 1'b0);
    wait_done(cyc);
    chk("t5 C[2][1]", acc[2][1], 3);
    chk("t5 C[3][3]", acc[3][3], 6);

    // Back-to-back with valid held through DONE
    fill(2);
    load(2 * NN, 1'b0, 1'b1);
    fill(7);
    load(2 * NN, 1'b0, 1'b0);
    chk("b2b first accept", longint'(first_after_done), 1);
    chk("b2b clear", longint'(bus.arr_clr), 1);
    wait_done(cyc);
    chk("b2b C[3][0]", acc[3][0], 6);
    chk("b2b C[0][2]", acc[0][2], -4);

    // Reset after 10 words, then a full tile
    fill(0);
    load(10, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fill(8);
    load(2 * NN, 1'b0, 1'b0);
    wait_done(cyc);
    chk("rstload C[1][3]", acc[1][3], 12);
    chk("rstload C[2][0]", acc[2][0], 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/systolic_operand_feeder.md
Name: systolic_operand_feeder

Overview:
- Front-end injector for an N x N output-stationary MAC array used to compute the DCT matrix product C = A * B.
- Each array PE latches its north operand southward but does not forward its west operand.
- This block buffers one A tile and one B tile from a valid/ready stream. It clears the array, then drives the north column inputs unskewed and the west row inputs skewed by row index.
- It then signals that every PE accumulator holds its C element.

Parameters:
- N, 4, array dimension (tile is N x N); N >= 2
- DW, 32, signed operand width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  load word valid
- in_ready  out  1  block accepts a load word (high only in LOAD)
- in_data  in  DW  signed operand word
- arr_clr  out  1  drives array PE reset; one-cycle pulse before each feed
- north_data  out  N*DW  column j operand at bits [j*DW +: DW], to top-row PE in_north
- west_data  out  N*DW  row i operand at bits [i*DW +: DW], broadcast to every PE in_west of row i
- busy  out  1  high in CLEAR, FEED and DONE
- tile_done  out  1  one-cycle pulse; array results valid and stable this cycle

Behaviour:
- Reset values:
  - state = LOAD, load count 0, feed count 0
  - in_ready = 1, arr_clr = 0, busy = 0, tile_done = 0
  - north_data = 0, west_data = 0
  - Buffer contents are don't-care.
- Rst mid-operation (any state) aborts the tile. It discards all partially loaded words and returns to the reset values on the next edge. arr_clr is not asserted by reset.
- LOAD:
  - A word transfers on an edge where in_valid & in_ready.
  - Words 0..N*N-1 fill A row-major (A[r][c] = word r*N+c).
  - Words N*N..2*N*N-1 fill B row-major.
  - The load count increments per transfer only.
  - When the final B word (count 2*N*N-1) transfers, the next state is CLEAR and in_ready drops the following cycle.
  - in_valid without in_ready is ignored.
- CLEAR: lasts 1 cycle. arr_clr = 1, busy = 1, north_data = west_data = 0.
- FEED:
  - Lasts exactly 2N-1 cycles, feed index f = 0..2N-2, counted from the first FEED cycle.
  - north column j: B[f][j] if f <= N-1, else 0.
  - west row i: A[i][f-i] if i <= f <= i+N-1, else 0.
  - Rationale: PE(i,j) sees north column j delayed i cycles through the out_south registers. Row i therefore pairs A[i][k] with B[k][j] at f = i+k.
- DONE:
  - Lasts 1 cycle. tile_done = 1, busy = 1, outputs 0.
  - The last array accumulate occurred on the edge ending FEED f = 2N-2, so all results are final in this cycle.
  - The next state is LOAD with in_ready = 1.
  - Zero operands keep the array results unchanged afterwards, until the next arr_clr.
- Latency: the last load word edge is followed by 1 CLEAR, 2N-1 FEED and 1 DONE cycle, i.e. 2N+1 cycles from CLEAR to DONE inclusive.
- Outputs are driven from registers. Operands change only at clock edges; there is no combinational path from in_valid or in_data to any output.
- Arithmetic: pure data movement, no width change. The signed value is passed bit-exact.
- No stall: the array has no enable, so FEED is never paused once started.
- Back-to-back tiles:
  - A new tile can load only after DONE; a word offered during busy is not accepted.
  - The A/B buffers are overwritten only in LOAD.
  - An in_valid held high from DONE onward is accepted on the first LOAD cycle.

Test Plan:
- N=4, A = identity, B[r][c] = r*4+c, in_valid continuous. Required:
  - in_ready high for 32 accepts, then arr_clr for 1 cycle.
  - 7 FEED cycles, then tile_done.
  - A reference 4x4 array model yields C[i][j] = i*4+j.
- Skew check, N=4, A[i][k] = 10*i+k, B = all 1. Required:
  - At f=3: west row0 = 3, row1 = 12, row2 = 21, row3 = 30.
  - At f=5: west row3 = 32, rows 0/1 = 0, north all 0.
- Throttled load: in_valid toggled 1,0,1,0, with negative values (A = -1s, B = 2s). Required:
  - Exactly 32 transfers, no duplication.
  - Array result = -8 in every PE.
- Reset mid-FEED: assert rst at f=2 for 1 cycle. Required:
  - Next cycle in LOAD with in_ready = 1, busy = 0, outputs 0, no tile_done.
  - A fresh full tile then completes correctly.
- Back-to-back tiles: second tile offered with in_valid held high through DONE. Required:
  - First word accepted on the cycle after tile_done.
  - arr_clr precedes second FEED.
  - Second result independent of first.
- Reset during LOAD after 10 words, then a full 32-word tile. Required: the result reflects only the 32 post-reset words.
